// File: rtl/rob_commit_sequencer_if.sv
// Dispatcher / CDB / register-file bundle of the ROB commit sequencer.
// The sequencer sits on the slave modport. The dispatcher and CDB drive from the master modport.
interface rob_commit_sequencer_if #(
  parameter int ID_W   = 5,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
);
  // Handshake: an allocation is taken on the rising edge only when
  // alloc_valid && alloc_ready. alloc_id is valid in the same cycle.
  // The CDB (wb_*) and commit/rollback ports are fire-and-forget strobes.
  // They are qualified by wb_valid, commit_flag and rollback_flag respectively.
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_rd;
  logic              alloc_ready;
  logic [ID_W-1:0]   alloc_id;
  logic              wb_valid;
  logic [ID_W-1:0]   wb_id;
  logic [DATA_W-1:0] wb_value;
  logic              wb_mispredict;
  logic [DATA_W-1:0] wb_target;
  logic              commit_flag;
  logic [REG_W-1:0]  commit_rd;
  logic [ID_W-1:0]   commit_id;
  logic [DATA_W-1:0] commit_value;
  logic              rollback_flag;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  logic [ID_W-1:0]   count;
  logic              fsm_state;  // debug: 1 while in the FLUSH bubble

  modport master (
    output alloc_valid, alloc_rd, wb_valid, wb_id, wb_value, wb_mispredict, wb_target,
    input  alloc_ready, alloc_id, commit_flag, commit_rd, commit_id, commit_value,
           rollback_flag, redirect_valid, redirect_pc, count, fsm_state
  );

  modport slave (
    input  alloc_valid, alloc_rd, wb_valid, wb_id, wb_value, wb_mispredict, wb_target,
    output alloc_ready, alloc_id, commit_flag, commit_rd, commit_id, commit_value,
           rollback_flag, redirect_valid, redirect_pc, count, fsm_state
  );
endinterface

// File: rtl/rob_commit_sequencer.sv
// In-order reorder buffer: allocates tags, collects CDB writebacks and retires one entry per cycle.
// A retiring mispredicted branch flushes everything and is followed by a one-cycle dispatch bubble.
module rob_commit_sequencer #(
  parameter int ROB_SIZE = 16,
  parameter int ID_W     = 5,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32
) (
  input logic clk,
  input logic rst,
  rob_commit_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(ROB_SIZE);

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t            state, state_next;
  logic [ROB_SIZE-1:0] busy, rdy, mis;
  logic [REG_W-1:0]  rd_q     [ROB_SIZE];
  logic [DATA_W-1:0] value_q  [ROB_SIZE];
  logic [DATA_W-1:0] target_q [ROB_SIZE];
  logic [PTR_W-1:0]  head, tail;
  logic [ID_W-1:0]   count;
  logic              commit, rollback, alloc_ok, alloc_fire, wb_hit;
  logic [PTR_W-1:0]  wb_idx;

  // Tag 0 means "no producer". Tags above ROB_SIZE cannot name an entry.
  assign wb_idx = PTR_W'(bus.wb_id - ID_W'(1));
  assign wb_hit = bus.wb_valid && (bus.wb_id != '0) &&
                  (bus.wb_id <= ID_W'(ROB_SIZE)) && busy[wb_idx];

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    rollback   = 1'b0;
    alloc_ok   = 1'b0;
    case (state)
      S_RUN: begin
        commit   = busy[head] && rdy[head];
        rollback = commit && mis[head];
        // Registered count only: a same-cycle retire never frees a slot early.
        alloc_ok = (count < ID_W'(ROB_SIZE)) && !rollback;
        if (rollback) state_next = S_FLUSH;
      end
      S_FLUSH: state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  assign alloc_fire         = bus.alloc_valid && alloc_ok;
  assign bus.alloc_ready    = alloc_ok;
  assign bus.alloc_id       = ID_W'(tail) + ID_W'(1);
  assign bus.commit_flag    = commit;
  assign bus.commit_rd      = commit ? rd_q[head] : '0;
  assign bus.commit_id      = commit ? ID_W'(head) + ID_W'(1) : '0;
  assign bus.commit_value   = commit ? value_q[head] : '0;
  assign bus.rollback_flag  = rollback;
  assign bus.redirect_valid = rollback;
  assign bus.redirect_pc    = rollback ? target_q[head] : '0;
  assign bus.count          = count;
  assign bus.fsm_state      = (state == S_FLUSH);

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      busy  <= '0;
      rdy   <= '0;
      mis   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wb_hit) begin
        rdy[wb_idx] <= 1'b1;
        mis[wb_idx] <= bus.wb_mispredict;
      end
      if (commit) begin
        busy[head] <= 1'b0;
        rdy[head]  <= 1'b0;
        mis[head]  <= 1'b0;
        head       <= head + 1'b1;
      end
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        rdy[tail]  <= 1'b0;
        mis[tail]  <= 1'b0;
        tail       <= tail + 1'b1;
      end
      case ({alloc_fire, commit})
        2'b10:   count <= count + ID_W'(1);
        2'b01:   count <= count - ID_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage is never read unless its busy/ready bits say so, hence no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) rd_q[tail] <= bus.alloc_rd;
    if (wb_hit && !rollback) begin
      value_q[wb_idx]  <= bus.wb_value;
      target_q[wb_idx] <= bus.wb_target;
    end
  end
endmodule

// File: tb/tb_rob_commit_sequencer.sv
// Randomized scoreboard bench for rob_commit_sequencer against an in-order queue model.
module tb_rob_commit_sequencer;
  localparam int ROB_SIZE = 16;
  localparam int ID_W     = 5;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int ST_W     = 4 + 2 * ID_W;
  localparam int CM_W     = 1 + REG_W + ID_W + 2 * DATA_W;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [REG_W-1:0]  rd;
    bit                ready;
    logic [DATA_W-1:0] value;
    bit                mis;
    logic [DATA_W-1:0] target;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rob_commit_sequencer_if #(.ID_W(ID_W), .REG_W(REG_W), .DATA_W(DATA_W)) bus ();

  rob_commit_sequencer #(.ROB_SIZE(ROB_SIZE), .ID_W(ID_W), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  logic [ST_W-1:0] st_q [$];   // per-cycle status: commit, rollback, flush, alloc_ready, alloc_id, count
  logic [CM_W-1:0] exp_q[$];   // per-commit: rollback, rd, id, value, redirect pc
  int checks   = 0;
  int failures = 0;

  // Reference model: ordered list of live entries plus the next tag to hand out
  ent_t            m_q[$];
  logic [ID_W-1:0] m_tag   = 1;
  bit              m_flush = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit av, input logic [REG_W-1:0] rd,
                       input bit wv, input logic [ID_W-1:0] wid, input logic [DATA_W-1:0] wval,
                       input bit wmis, input logic [DATA_W-1:0] wtgt, input bit r);
    bit c, rb, ar;
    int sz;
    ent_t e;
    @(negedge clk);
    sz = m_q.size();
    c  = !m_flush && (sz > 0) && m_q[0].ready;
    rb = c && m_q[0].mis;
    ar = !m_flush && (sz < ROB_SIZE) && !rb;
    st_q.push_back({c, rb, m_flush, ar, m_tag, ID_W'(sz)});
    if (c) exp_q.push_back({rb, m_q[0].rd, m_q[0].id, m_q[0].value, m_q[0].target});
    bus.alloc_valid   = av;
    bus.alloc_rd      = rd;
    bus.wb_valid      = wv;
    bus.wb_id         = wid;
    bus.wb_value      = wval;
    bus.wb_mispredict = wmis;
    bus.wb_target     = wtgt;
    rst               = r;
    if (r) begin
      m_q.delete(); m_tag = 1; m_flush = 0;
    end else if (rb) begin
      m_q.delete(); m_tag = 1; m_flush = 1;
    end else begin
      m_flush = 0;
      if (wv) begin
        foreach (m_q[i]) begin
          if (m_q[i].id == wid) begin
            m_q[i].ready  = 1;
            m_q[i].value  = wval;
            m_q[i].mis    = wmis;
            m_q[i].target = wtgt;
          end
        end
      end
      if (c) void'(m_q.pop_front());
      if (av && ar) begin
        e.id = m_tag; e.rd = rd; e.ready = 0; e.value = '0; e.mis = 0; e.target = '0;
        m_q.push_back(e);
        m_tag = (m_tag == ID_W'(ROB_SIZE)) ? ID_W'(1) : m_tag + ID_W'(1);
      end
    end
  endtask

  task automatic idle();                  cycle(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_reset();              cycle(0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic alloc(input int rd);     cycle(1, REG_W'(rd), 0, 0, 0, 0, 0, 0); endtask
  task automatic wb(input int id, input logic [DATA_W-1:0] v, input bit m, input logic [DATA_W-1:0] t, input bit av);
    cycle(av, 0, 1, ID_W'(id), v, m, t, 0);
  endtask

  // Monitor: sample settled outputs mid-cycle and pop the scoreboard
  initial begin
    logic [ST_W-1:0] s;
    logic [CM_W-1:0] x;
    forever begin
      @(negedge clk);
      #2;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        check("commit_flag",    64'(bus.commit_flag),    64'(s[ST_W-1]));
        check("rollback_flag",  64'(bus.rollback_flag),  64'(s[ST_W-2]));
        check("redirect_valid", 64'(bus.redirect_valid), 64'(s[ST_W-2]));
        check("fsm_flush",      64'(bus.fsm_state),      64'(s[ST_W-3]));
        check("alloc_ready",    64'(bus.alloc_ready),    64'(s[ST_W-4]));
        check("alloc_id",       64'(bus.alloc_id),       64'(s[2*ID_W-1:ID_W]));
        check("count",          64'(bus.count),          64'(s[ID_W-1:0]));
      end
      if (bus.commit_flag === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 64'(bus.commit_id), 64'(0));
          if (bus.commit_id == 0) begin
            failures++;
            $display("FAIL unexpected_commit: commit with empty scoreboard at %0t", $time);
          end
        end else begin
          x = exp_q.pop_front();
          check("commit_rd",    64'(bus.commit_rd),    64'(x[CM_W-2 -: REG_W]));
          check("commit_id",    64'(bus.commit_id),    64'(x[CM_W-2-REG_W -: ID_W]));
          check("commit_value", 64'(bus.commit_value), 64'(x[2*DATA_W-1:DATA_W]));
          if (x[CM_W-1]) check("redirect_pc", 64'(bus.redirect_pc), 64'(x[DATA_W-1:0]));
        end
      end
    end
  end

  initial begin
    bit av, wv, wm, r;
    logic [ID_W-1:0] wid;
    bus.alloc_valid = 0; bus.alloc_rd = 0; bus.wb_valid = 0; bus.wb_id = 0;
    bus.wb_value = 0; bus.wb_mispredict = 0; bus.wb_target = 0;
    repeat (2) @(posedge clk);

    // Basic allocation and out-of-order writeback, in-order retire
    alloc(3); alloc(5); alloc(7); idle();
    wb(2, 32'hAA, 0, 0, 0);
    wb(1, 32'h55, 0, 0, 0);
    idle(); idle(); idle();

    // Fill to capacity, retire one, refuse same-cycle alloc, then wrap to tag 1
    do_reset();
    for (int i = 0; i < ROB_SIZE; i++) alloc(i + 1);
    alloc(30);
    wb(1, 32'h1234, 0, 0, 0);
    alloc(31);
    alloc(29);
    idle();

    // Mispredict rollback with a concurrent allocation request
    do_reset();
    alloc(4); alloc(6);
    wb(1, 32'h77, 1, 32'h1000, 1);
    alloc(8); alloc(9); alloc(10); idle();

    // Ignored writebacks: tag 0 and a non-busy tag
    do_reset();
    alloc(1); alloc(2); alloc(3);
    wb(0, 32'hDEAD, 0, 0, 0);
    wb(9, 32'hBEEF, 1, 32'h40, 0);
    idle();

    // Reset mid-operation
    for (int i = 0; i < 2; i++) alloc(i + 11);
    do_reset();
    for (int i = 0; i < 5; i++) alloc(i + 11);
    do_reset();
    idle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      av = ($urandom_range(0, 99) < 60);
      wv = ($urandom_range(0, 99) < 55);
      wm = ($urandom_range(0, 24) == 0);
      r  = ($urandom_range(0, 299) == 0);
      if (m_q.size() > 0 && $urandom_range(0, 9) < 8)
        wid = m_q[$urandom_range(0, m_q.size() - 1)].id;
      else
        wid = ID_W'($urandom_range(0, 31));
      cycle(av, REG_W'($urandom_range(0, 31)), wv, wid, $urandom, wm, $urandom, r);
    end

    do_reset();
    idle(); idle();
    @(negedge clk);
    #5;
    check("commits_drained", 64'(exp_q.size()), 64'(0));
    check("status_drained",  64'(st_q.size()),  64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rob_commit_sequencer.md
Name: rob_commit_sequencer

Overview:
- In-order retirement controller for the rename register file. Allocates reorder-buffer IDs to the dispatcher and collects CDB writebacks.
- Commits at most one entry per cycle into the register file's commit port.
- Sequences branch-mispredict rollback: flushes all entries, broadcasts the rollback flag and a PC redirect, then holds a one-cycle dispatch bubble.

Parameters:
ROB_SIZE, 16, number of entries (power of two)
ID_W, 5, tag width; tag 0 is ZERO_ROB (no producer), so valid tags are 1..ROB_SIZE
REG_W, 5, architectural register index width
DATA_W, 32, data/PC width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alloc_valid  in  1  dispatcher requests an entry this cycle
alloc_rd  in  REG_W  destination register (0 = none)
alloc_ready  out  1  entry available; an allocation is taken only when alloc_valid && alloc_ready
alloc_id  out  ID_W  tag given to the current request (tail index + 1)
wb_valid  in  1  CDB result valid
wb_id  in  ID_W  tag of the result
wb_value  in  DATA_W  result value
wb_mispredict  in  1  entry is a mispredicted control-flow instruction
wb_target  in  DATA_W  correct PC when mispredicted
commit_flag  out  1  head entry retires this cycle
commit_rd  out  REG_W  head destination register
commit_id  out  ID_W  head tag (compared against the RegFile Q entry)
commit_value  out  DATA_W  head value
rollback_flag  out  1  flush all rename state this cycle
redirect_valid  out  1  fetch redirect, asserted with rollback_flag
redirect_pc  out  DATA_W  redirect target
count  out  ID_W  occupied entries (0..ROB_SIZE)

Behaviour:
- Storage per entry: busy, ready, rd, value, mispredict, target. Head and tail pointers are log2(ROB_SIZE) bits and wrap modulo ROB_SIZE. count is held in a separate register.
- FSM has two states:
  - RUN: normal operation.
  - FLUSH: one cycle, alloc_ready=0, no commit; returns to RUN next cycle.
- Reset: all entries not busy; head=tail=0; count=0; state RUN. All outputs 0 except alloc_ready=1 and alloc_id=1.
- alloc_ready = (state==RUN) && (count<ROB_SIZE) && !rollback_flag.
  - It is computed from registered count only. A same-cycle commit does not free a slot for a same-cycle allocation.
- Allocation: on the clock edge the tail entry is written with busy=1, ready=0, rd=alloc_rd, mispredict=0. The tail advances with wrap. alloc_id = tail+1 and is valid in the same cycle, combinationally.
- Writeback: if wb_valid and entry (wb_id-1) is busy, set ready=1 and latch value, mispredict and target on the edge.
  - wb_id=0 and writebacks to non-busy entries are ignored.
  - A writeback to the head is visible for commit the following cycle, not the same cycle.
- Commit is combinational from registered state. commit_flag = (state==RUN) && head busy && head ready.
  - commit_rd, commit_id (=head+1) and commit_value reflect the head entry.
  - On the edge: head is cleared, head advances and count decrements.
- Rollback: if a committing head has mispredict=1, then in the same cycle:
  - commit_flag=1 (its rd/value still retire);
  - rollback_flag=1, redirect_valid=1, redirect_pc=head target.
  - On the edge, all entries are cleared, head=tail=0, count=0 and state goes to FLUSH.
  - Allocations in the rollback cycle are refused (alloc_ready=0) and writebacks are discarded.
- Simultaneous allocation and commit (non-rollback): count is unchanged; both pointers advance.
- Full: count==ROB_SIZE, alloc_ready=0, tail==head. Empty: count==0, commit_flag=0.
- rollback_flag and redirect_valid are one-cycle pulses; they are 0 in FLUSH and RUN otherwise.
- rst asserted mid-operation (including during FLUSH or the rollback cycle) returns the block to the reset state on the next edge. It has priority over every other event.

Test Plan:
- Reset, allocate rd=3,5,7 on three cycles -> alloc_id 1,2,3; count=3; commit_flag stays 0.
- Writeback id=2 (value 0xAA), then id=1 (value 0x55) -> cycle after id 1's writeback: commit_flag=1, commit_rd=3, commit_id=1, commit_value=0x55; next cycle id 2 commits rd=5 value 0xAA; count=1.
- Allocate 16 entries without writeback -> alloc_ready=0 at count=16. Writeback id=1 -> commit next cycle. In that commit cycle, an alloc_valid is refused. Next cycle alloc_ready=1 and alloc_id=1 (wrap).
- Head id=1 written back with mispredict=1, target 0x1000, while alloc_valid=1 -> commit_flag=1, rollback_flag=1, redirect_pc=0x1000, alloc_ready=0. Next cycle FLUSH: count=0, alloc_ready=0. Following cycle alloc_id=1.
- wb_valid with wb_id=0 and with a non-busy id=9 -> no state change, count unchanged.
- Assert rst for one cycle with count=5 -> count=0, alloc_ready=1, commit_flag=0, rollback_flag=0.
